// File: rtl/add_seq_pkg.sv
// ============================================================================
// add_seq_pkg : shared types for the multi-word add/sub sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package add_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic s;
    logic p;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/add16_slice.sv
// ============================================================================
// add16_slice : combinational 16-bit adder slice with carry into MSB
// Rev 1.0
// ============================================================================
`default_nettype none

module add16_slice
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout,
  output logic              cin_msb
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
  // Carry into the top bit recovered from the sum bit, avoiding a second adder.
  assign cin_msb = s[WORD_W-1] ^ a[WORD_W-1] ^ b[WORD_W-1];

endmodule

`default_nettype wire

// File: rtl/add_seq_multiword.sv
// ============================================================================
// add_seq_multiword : WORDS x 16-bit add/sub, one word per cycle, LS first.
// Optional macro ADD_SEQ_CIN_EN adds a cin port (initial carry = cin ^ sub).
// Rev 1.0
// ============================================================================
`default_nettype none

module add_seq_multiword
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
`ifdef ADD_SEQ_CIN_EN
  input  logic                   cin,
`endif
  input  logic [WORDS*WORD_W-1:0] op_a,
  input  logic [WORDS*WORD_W-1:0] op_b,
  output logic                   busy,
  output logic                   done,
  output logic [WORDS*WORD_W-1:0] sum,
  output logic                   carry,
  output logic                   overflow,
  output logic                   zero,
  output logic                   sign,
  output logic                   parity
);

  localparam int N     = WORDS * WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic [N-1:0]     work_q, work_d, sum_q, sum_d;
  logic             sub_q, sub_d, c_q, c_d, done_q, done_d;
  flags_t           flags_q, flags_d;

  logic              cin0;
  logic [WORD_W-1:0] slice_a, slice_b, slice_s;
  logic              slice_cout, slice_cin_msb;

`ifdef ADD_SEQ_CIN_EN
  assign cin0 = cin ^ sub;
`else
  assign cin0 = sub;
`endif

  assign slice_a = a_q[idx_q*WORD_W +: WORD_W];
  assign slice_b = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};

  add16_slice u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .cin     (c_q),
    .s       (slice_s),
    .cout    (slice_cout),
    .cin_msb (slice_cin_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    work_d  = work_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          c_d     = cin0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[idx_q*WORD_W +: WORD_W] = slice_s;
        c_d   = slice_cout;
        idx_d = idx_q + 1'b1;
        // Publish only the complete result so outputs never expose partial words.
        if (idx_q == LAST_IDX) begin
          state_d   = IDLE;
          idx_d     = '0;
          sum_d     = work_d;
          flags_d.c = slice_cout;
          flags_d.v = slice_cin_msb ^ slice_cout;
          flags_d.z = ~|work_d;
          flags_d.s = work_d[N-1];
          flags_d.p = ^work_d;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = flags_q.c;
  assign overflow = flags_q.v;
  assign zero     = flags_q.z;
  assign sign     = flags_q.s;
  assign parity   = flags_q.p;

endmodule

`default_nettype wire

// File: tb/tb_add_seq_multiword.sv
// ============================================================================
// tb_add_seq_multiword : scoreboard bench for add_seq_multiword (WORDS=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_seq_multiword;

  localparam int WORDS = 4;
  localparam int N     = WORDS * 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [N-1:0] op_a  = '0;
  logic [N-1:0] op_b  = '0;
`ifdef ADD_SEQ_CIN_EN
  logic         cin   = 1'b0;
`endif
  logic         busy, done, carry, overflow, zero, sign, parity;
  logic [N-1:0] sum;

  add_seq_multiword #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
`ifdef ADD_SEQ_CIN_EN
    .cin      (cin),
`endif
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign),
    .parity   (parity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] sum;
    logic [4:0]  fl;   // {c, v, z, s, p}
    logic [31:0] acc;  // cycle count at the accepting edge
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("sum", sum, mon_e.sum);
        chk("flags_cvzsp", {59'd0, carry, overflow, zero, sign, parity}, {59'd0, mon_e.fl});
        chk("latency", 64'(cyc - int'(mon_e.acc)), 64'd4);
      end
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic s, input logic ci);
    op_a = a;
    op_b = b;
    sub  = s;
`ifdef ADD_SEQ_CIN_EN
    cin  = ci;
`else
    if (ci) op_a = a;
`endif
    start = 1'b1;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic ci,
                       input logic [63:0] es, input logic [4:0] ef);
    @(posedge clk); #1;
    drive(a, b, s, ci);
    q.push_back('{es, ef, 32'(cyc + 1)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_sum"}, sum, 64'd0);
    chk({tag, "_flags"}, {59'd0, carry, overflow, zero, sign, parity}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic additions and subtractions
    issue(64'h0000_0000_0000_8FFF, 64'h0000_0000_0000_8000, 1'b0, 1'b0,
          64'h0000_0000_0001_0FFF, 5'b00001);
    drain();
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0002, 1'b0, 1'b0,
          64'h0, 5'b10100);
    drain();
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 5'b01011);
    drain();
    issue(64'h0, 64'h1, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 5'b00010);
    drain();
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0,
          64'h0, 5'b10100);
    drain();
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
          64'h2222_2222_2222_2211, 5'b00000);
    drain();

    // start pulses while busy must be ignored
    dc0 = done_cnt;
    issue(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 5'b00001);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    drive(64'hFFFF_0000_FFFF_0000, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = 64'hDEAD_BEEF_DEAD_BEEF;
    drain();
    repeat (6) @(negedge clk);
    chk("single_done", 64'(done_cnt - dc0), 64'd1);

    // start held in the done cycle is accepted back-to-back
    issue(64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 5'b10001);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", {63'd0, done}, 64'd1);
    drive(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0);
    q.push_back('{64'h0, 5'b10100, 32'(cyc + 1)});
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Reset mid-run aborts without a done pulse
    dc0 = done_cnt;
    issue(64'h0000_0000_0000_8FFF, 64'h0000_0000_0000_8000, 1'b0, 1'b0,
          64'h0000_0000_0001_0FFF, 5'b00001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk_reset_outputs("abort");
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    rst_n = 1'b1;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 5'b01011);
    drain();

`ifdef ADD_SEQ_CIN_EN
    issue(64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 5'b00001);
    drain();
    issue(64'h5, 64'h3, 1'b1, 1'b1, 64'h1, 5'b10001);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
